cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Top-level inference controller for the two-stage conv/pool pipeline: image memory -> layer1 -> layer1 memory -> layer2 -> layer2 memory.
- Starts each frame, issues layer start pulses, and counts per-output-channel completions.
- Confirms pooling completion, runs a progress watchdog, and reports busy/done/error status to the system.
- Replaces the hard-tied layer1 start and the direct pool_done -> layer2 start chaining.

Parameters:
- OC1, 7: index of last layer1 output channel (layer1 has OC1+1 channels).
- OC2, 15: index of last layer2 output channel (layer2 has OC2+1 channels).
- TIMEOUT, 4095: maximum cycles allowed between progress events before error.
- TO_W, 12: watchdog counter width; TIMEOUT must be < 2^TO_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- frame_start  in  1  single-cycle request to run one inference
- abort  in  1  cancel current frame
- img_ready  in  1  image memory loaded and valid
- l1_start  out  1  single-cycle start pulse to layer1
- l1_cout_done  in  1  pulse: one layer1 output channel finished
- l1_pool_done  in  1  pulse: layer1 pooling finished
- l2_start  out  1  single-cycle start pulse to layer2
- l2_cout_done  in  1  pulse: one layer2 output channel finished
- l2_pool_done  in  1  pulse: layer2 pooling finished
- busy  out  1  high from accepted frame_start until DONE/ERROR/IDLE
- done  out  1  single-cycle pulse: frame complete
- err  out  1  sticky error flag
- err_code  out  2  01 timeout, 10 protocol, 11 abort
- ch_count  out  4  completed channels in the current layer
- state  out  3  current FSM state encoding
- frame_cnt  out  8  completed frames, wraps 255 -> 0

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high on clk.
  - rst forces IDLE in the same edge, including mid-frame.
  - Reset values: all outputs 0; ch_count 0; frame_cnt 0; err 0; err_code 00; watchdog 0.
- States (encoding): IDLE 0, WAIT_IMG 1, L1_RUN 2, L1_POOL 3, L2_RUN 4, L2_POOL 5, DONE 6, ERROR 7.
- IDLE:
  - frame_start=1 -> WAIT_IMG; busy rises next cycle.
  - frame_start is ignored in every other state (no queuing).
- WAIT_IMG:
  - img_ready=1 -> L1_RUN; l1_start=1 for exactly the cycle the state becomes L1_RUN; ch_count cleared.
- L1_RUN:
  - Each l1_cout_done increments ch_count.
  - On the pulse making ch_count == OC1+1 -> L1_POOL.
  - l1_pool_done here -> ERROR, code 10.
- L1_POOL:
  - l1_pool_done -> L2_RUN; l2_start pulses one cycle; ch_count cleared.
  - Extra l1_cout_done -> ERROR, code 10.
- L2_RUN / L2_POOL: identical rules using OC2 and the l2_* signals.
- L2_POOL completion: l2_pool_done -> DONE.
- DONE (one cycle):
  - done=1, frame_cnt+1, busy=0 -> IDLE.
- ERROR:
  - err=1 sticky, busy=0.
  - Exit only via frame_start, which clears err/err_code and goes to WAIT_IMG.
- Watchdog:
  - Counts in WAIT_IMG..L2_POOL; cleared on state change and on any *_done input.
  - Reaching TIMEOUT -> ERROR, code 01.
  - Inactive in IDLE/DONE/ERROR.
- abort:
  - abort=1 in any busy state -> ERROR, code 11.
  - Ignored in IDLE/DONE/ERROR.
- Simultaneous events, priority: rst > abort > protocol error > timeout > normal transition.
- Done inputs for the layer not currently active are ignored.
- Outputs:
  - All outputs are registered.
  - Start pulses never exceed one cycle.
  - ch_count saturates at 15 and never wraps within a layer.

Test Plan:
- Normal frame:
  - Stimulus: frame_start, img_ready at cycle 3, 8 l1_cout_done, l1_pool_done, 16 l2_cout_done, l2_pool_done.
  - Required: exactly one l1_start and one l2_start; ch_count reaches 8, then 16 saturated at 15; done one cycle; frame_cnt=1; busy low after.
- Protocol error:
  - Stimulus: l1_pool_done after only 5 l1_cout_done.
  - Required: state=7, err=1, err_code=10, no l2_start.
- Timeout:
  - Stimulus: TIMEOUT=20, img_ready never asserted.
  - Required: ERROR with code 01 exactly 20 cycles after entering WAIT_IMG; no l1_start.
- Abort and recovery:
  - Stimulus: abort mid-L2_RUN, then frame_start.
  - Required: err_code=11; the next frame_start clears err and the full frame completes; frame_cnt increments.
- Reset mid-frame:
  - Stimulus: rst asserted in L1_POOL.
  - Required: next edge gives state=0, all outputs 0; a subsequent frame runs normally.
- Rollover and ignored requests:
  - Stimulus: 256 back-to-back frames; frame_start pulses issued while busy.
  - Required: frame_cnt wraps to 0; frame_start while busy has no effect.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Frame-level sequencer for the two-layer conv/pool pipeline: issues layer start
// pulses, counts per-channel completions, checks pooling order and guards progress.
module cnn_layer_sequencer #(
  parameter int OC1     = 7,
  parameter int OC2     = 15,
  parameter int TIMEOUT = 4095,
  parameter int TO_W    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       abort,
  input  logic       img_ready,
  output logic       l1_start,
  input  logic       l1_cout_done,
  input  logic       l1_pool_done,
  output logic       l2_start,
  input  logic       l2_cout_done,
  input  logic       l2_pool_done,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [3:0] ch_count,
  output logic [2:0] state,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IMG = 3'd1;
  localparam logic [2:0] S_L1_RUN   = 3'd2;
  localparam logic [2:0] S_L1_POOL  = 3'd3;
  localparam logic [2:0] S_L2_RUN   = 3'd4;
  localparam logic [2:0] S_L2_POOL  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam logic [1:0] E_TIMEOUT  = 2'b01;
  localparam logic [1:0] E_PROTO    = 2'b10;
  localparam logic [1:0] E_ABORT    = 2'b11;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [4:0]      L1_CH   = 5'(OC1 + 1);
  localparam logic [4:0]      L2_CH   = 5'(OC2 + 1);

  // The internal count reaches 16 for a full layer2; the visible count stops at 15.
  function automatic logic [3:0] sat_ch(input logic [4:0] c);
    return (c > 5'd15) ? 4'd15 : c[3:0];
  endfunction

  function automatic logic is_active(input logic [2:0] s);
    return (s >= S_WAIT_IMG) && (s <= S_L2_POOL);
  endfunction

  logic [2:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [1:0]      ecode_d;
  logic            proto_err;
  logic            any_done;
  logic            active_q;

  assign state    = state_q;
  assign active_q = is_active(state_q);
  assign any_done = l1_cout_done | l1_pool_done | l2_cout_done | l2_pool_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ecode_d   = 2'b00;
    proto_err = 1'b0;
    wd_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_WAIT_IMG;
          cnt_d   = '0;
        end
      end
      S_WAIT_IMG: begin
        if (img_ready) begin
          state_d = S_L1_RUN;
          cnt_d   = '0;
        end
      end
      S_L1_RUN: begin
        if (l1_pool_done) begin
          proto_err = 1'b1;
        end else if (l1_cout_done) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_d == L1_CH) state_d = S_L1_POOL;
        end
      end
      S_L1_POOL: begin
        if (l1_cout_done) begin
          proto_err = 1'b1;
        end else if (l1_pool_done) begin
          state_d = S_L2_RUN;
          cnt_d   = '0;
        end
      end
      S_L2_RUN: begin
        if (l2_pool_done) begin
          proto_err = 1'b1;
        end else if (l2_cout_done) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_d == L2_CH) state_d = S_L2_POOL;
        end
      end
      S_L2_POOL: begin
        if (l2_cout_done) begin
          proto_err = 1'b1;
        end else if (l2_pool_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERROR: begin
        if (frame_start) begin
          state_d = S_WAIT_IMG;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Fault priority: abort over protocol over timeout over the normal move.
    if (active_q && abort) begin
      state_d = S_ERROR;
      cnt_d   = cnt_q;
      ecode_d = E_ABORT;
    end else if (proto_err) begin
      state_d = S_ERROR;
      cnt_d   = cnt_q;
      ecode_d = E_PROTO;
    end else if (active_q && (wd_q == WD_LAST)) begin
      state_d = S_ERROR;
      cnt_d   = cnt_q;
      ecode_d = E_TIMEOUT;
    end

    if (active_q && (state_d == state_q) && !any_done) wd_d = wd_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      l1_start  <= 1'b0;
      l2_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      ch_count  <= '0;
      frame_cnt <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      ch_count <= sat_ch(cnt_d);
      busy     <= is_active(state_d);
      done     <= (state_d == S_DONE);
      l1_start <= (state_q == S_WAIT_IMG) && (state_d == S_L1_RUN);
      l2_start <= (state_q == S_L1_POOL) && (state_d == S_L2_RUN);
      if (state_d == S_DONE) frame_cnt <= frame_cnt + 8'd1;
      if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
        err      <= 1'b1;
        err_code <= ecode_d;
      end else if ((state_q == S_ERROR) && (state_d != S_ERROR)) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: normal frames, protocol/timeout/abort
// errors, reset mid-frame and frame counter rollover.
module tb_cnn_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic       img_ready = 1'b0;
  logic       l1_start;
  logic       l1_cout_done = 1'b0;
  logic       l1_pool_done = 1'b0;
  logic       l2_start;
  logic       l2_cout_done = 1'b0;
  logic       l2_pool_done = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [3:0] ch_count;
  logic [2:0] state;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int l1s_cnt = 0;
  int l2s_cnt = 0;
  int done_cnt = 0;

  cnn_layer_sequencer #(.OC1(7), .OC2(15), .TIMEOUT(20), .TO_W(12)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .img_ready(img_ready), .l1_start(l1_start), .l1_cout_done(l1_cout_done),
    .l1_pool_done(l1_pool_done), .l2_start(l2_start), .l2_cout_done(l2_cout_done),
    .l2_pool_done(l2_pool_done), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .ch_count(ch_count), .state(state), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (l1_start) l1s_cnt++;
    if (l2_start) l2s_cnt++;
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic quick_body(input bit spam);
    img_ready = 1'b1; frame_start = spam; step(); img_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin l1_cout_done = 1'b1; step(); l1_cout_done = 1'b0; end
    l1_pool_done = 1'b1; step(); l1_pool_done = 1'b0;
    for (int i = 0; i < 16; i++) begin l2_cout_done = 1'b1; step(); l2_cout_done = 1'b0; end
    l2_pool_done = 1'b1; step(); l2_pool_done = 1'b0;
    step();
    frame_start = 1'b0;
  endtask

  task automatic quick_frame(input bit spam);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    quick_body(spam);
  endtask

  task automatic test_reset();
    logic [22:0] outs;
    do_reset();
    outs = {l1_start, l2_start, busy, done, err, err_code, ch_count, state, frame_cnt};
    checks++;
    if (outs !== 23'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (state !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_in_idle: state %0d err %0b expected state 0 err 0", state, err);
    end
  endtask

  task automatic test_normal_frame();
    int b1, b2, exp;
    b1 = l1s_cnt; b2 = l2s_cnt;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    checks++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL nf_wait_img: state %0d busy %0b expected 1 1", state, busy);
    end
    step(); step();
    img_ready = 1'b1; step(); img_ready = 1'b0;
    checks++;
    if (state !== 3'd2 || l1_start !== 1'b1 || ch_count !== 4'd0) begin
      errors++; $display("FAIL nf_l1_start: state %0d l1_start %0b ch %0d expected 2 1 0", state, l1_start, ch_count);
    end
    for (int i = 0; i < 8; i++) begin
      l1_cout_done = 1'b1; step(); l1_cout_done = 1'b0;
      checks++;
      if (ch_count !== 4'(i + 1) || state !== ((i == 7) ? 3'd3 : 3'd2) || l1_start !== 1'b0) begin
        errors++; $display("FAIL nf_l1_count %0d: ch %0d state %0d l1_start %0b expected ch %0d", i, ch_count, state, l1_start, i + 1);
      end
      step();
    end
    l1_pool_done = 1'b1; step(); l1_pool_done = 1'b0;
    checks++;
    if (state !== 3'd4 || l2_start !== 1'b1 || ch_count !== 4'd0) begin
      errors++; $display("FAIL nf_l2_start: state %0d l2_start %0b ch %0d expected 4 1 0", state, l2_start, ch_count);
    end
    for (int i = 0; i < 16; i++) begin
      l2_cout_done = 1'b1; step(); l2_cout_done = 1'b0;
      exp = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (ch_count !== 4'(exp) || state !== ((i == 15) ? 3'd5 : 3'd4)) begin
        errors++; $display("FAIL nf_l2_count %0d: ch %0d state %0d expected ch %0d", i, ch_count, state, exp);
      end
      step();
    end
    l2_pool_done = 1'b1; step(); l2_pool_done = 1'b0;
    checks++;
    if (state !== 3'd6 || done !== 1'b1 || frame_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL nf_done: state %0d done %0b frames %0d busy %0b expected 6 1 1 0", state, done, frame_cnt, busy);
    end
    step();
    checks++;
    if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nf_idle: state %0d done %0b busy %0b expected 0 0 0", state, done, busy);
    end
    checks++;
    if (l1s_cnt - b1 !== 1 || l2s_cnt - b2 !== 1) begin
      errors++; $display("FAIL nf_start_pulses: l1 %0d l2 %0d expected 1 1", l1s_cnt - b1, l2s_cnt - b2);
    end
  endtask

  task automatic test_protocol_error();
    int b2;
    do_reset();
    b2 = l2s_cnt;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    img_ready = 1'b1; step(); img_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin l1_cout_done = 1'b1; step(); l1_cout_done = 1'b0; end
    l2_pool_done = 1'b1; l2_cout_done = 1'b1; step(); l2_pool_done = 1'b0; l2_cout_done = 1'b0;
    checks++;
    if (state !== 3'd2 || ch_count !== 4'd5 || err !== 1'b0) begin
      errors++; $display("FAIL pe_inactive_layer: state %0d ch %0d err %0b expected 2 5 0", state, ch_count, err);
    end
    l1_pool_done = 1'b1; step(); l1_pool_done = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd7 || err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0) begin
      errors++; $display("FAIL pe_error: state %0d err %0b code %b busy %0b expected 7 1 10 0", state, err, err_code, busy);
    end
    checks++;
    if (l2s_cnt - b2 !== 0) begin
      errors++; $display("FAIL pe_no_l2_start: got %0d expected 0", l2s_cnt - b2);
    end
  endtask

  task automatic test_timeout();
    int b1;
    do_reset();
    b1 = l1s_cnt;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    checks++;
    if (state !== 3'd1 || err !== 1'b0) begin
      errors++; $display("FAIL to_before: state %0d err %0b expected 1 0", state, err);
    end
    step();
    checks++;
    if (state !== 3'd7 || err !== 1'b1 || err_code !== 2'b01) begin
      errors++; $display("FAIL to_error: state %0d err %0b code %b expected 7 1 01", state, err, err_code);
    end
    checks++;
    if (l1s_cnt - b1 !== 0) begin
      errors++; $display("FAIL to_no_l1_start: got %0d expected 0", l1s_cnt - b1);
    end
  endtask

  task automatic test_abort_recovery();
    int bd;
    do_reset();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    img_ready = 1'b1; step(); img_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin l1_cout_done = 1'b1; step(); l1_cout_done = 1'b0; end
    l1_pool_done = 1'b1; step(); l1_pool_done = 1'b0;
    for (int i = 0; i < 3; i++) begin l2_cout_done = 1'b1; step(); l2_cout_done = 1'b0; end
    checks++;
    if (state !== 3'd4) begin
      errors++; $display("FAIL ab_in_l2_run: state %0d expected 4", state);
    end
    abort = 1'b1; l2_cout_done = 1'b1; step(); abort = 1'b0; l2_cout_done = 1'b0;
    checks++;
    if (state !== 3'd7 || err !== 1'b1 || err_code !== 2'b11) begin
      errors++; $display("FAIL ab_error: state %0d err %0b code %b expected 7 1 11", state, err, err_code);
    end
    bd = done_cnt;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    checks++;
    if (state !== 3'd1 || err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL ab_restart: state %0d err %0b code %b busy %0b expected 1 0 00 1", state, err, err_code, busy);
    end
    quick_body(1'b0);
    checks++;
    if (frame_cnt !== 8'd1 || done_cnt - bd !== 1 || state !== 3'd0) begin
      errors++; $display("FAIL ab_recovered_frame: frames %0d dones %0d state %0d expected 1 1 0", frame_cnt, done_cnt - bd, state);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [22:0] outs;
    do_reset();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    img_ready = 1'b1; step(); img_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin l1_cout_done = 1'b1; step(); l1_cout_done = 1'b0; end
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL rm_in_l1_pool: state %0d expected 3", state);
    end
    rst = 1'b1; l1_pool_done = 1'b1; step(); rst = 1'b0; l1_pool_done = 1'b0;
    outs = {l1_start, l2_start, busy, done, err, err_code, ch_count, state, frame_cnt};
    checks++;
    if (outs !== 23'd0) begin
      errors++; $display("FAIL rm_outputs: got %h expected 0", outs);
    end
    quick_frame(1'b0);
    checks++;
    if (frame_cnt !== 8'd1 || state !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rm_next_frame: frames %0d state %0d err %0b expected 1 0 0", frame_cnt, state, err);
    end
  endtask

  task automatic test_back_to_back();
    int exp_frames, bd, b1;
    do_reset();
    exp_frames = 0;
    bd = done_cnt; b1 = l1s_cnt;
    for (int i = 0; i < 256; i++) begin
      quick_frame(i[0]);
      exp_frames = (exp_frames + 1) % 256;
      checks++;
      if (state !== 3'd0 || frame_cnt !== 8'(exp_frames)) begin
        errors++; $display("FAIL b2b_frame %0d: state %0d frames %0d expected 0 %0d", i, state, frame_cnt, exp_frames);
      end
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL b2b_wrap: frames %0d expected 0", frame_cnt);
    end
    checks++;
    if (done_cnt - bd !== 256 || l1s_cnt - b1 !== 256) begin
      errors++; $display("FAIL b2b_pulses: dones %0d l1_starts %0d expected 256 256", done_cnt - bd, l1s_cnt - b1);
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_protocol_error();
    test_timeout();
    test_abort_recovery();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
